// File: rtl/csa_pkg.sv
// Shared definitions for the byte-serial carry-select adder controller.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

    // Byte index needs at least one bit even when NBYTES == 1.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/csa_8.sv
// 8-bit carry-select adder: ripple low nibble, high nibble precomputed for both carries.
module csa_8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    output logic [7:0] SUM,
    output logic       CARRY
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    always_comb begin
        lo  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0, CIN};
        hi0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
        hi1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;
        SUM   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
        CARRY = lo[4] ? hi1[4] : hi0[4];
    end

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-precision add/subtract: one shared csa_8 walks the operands LSB byte first,
// chaining carry through a register; results returned over a valid/ready handshake.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START_VALID,
    output logic                   START_READY,
    input  logic [BYTE_W*NBYTES-1:0] A,
    input  logic [BYTE_W*NBYTES-1:0] B,
    input  logic                   CIN,
    input  logic                   SUB,
    output logic [BYTE_W*NBYTES-1:0] RESULT,
    output logic                   COUT,
    output logic                   OVF,
    output logic                   DONE_VALID,
    input  logic                   DONE_READY
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_w(NBYTES);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, result_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q, cout_q, ovf_q;
    logic [7:0]      a_byte, b_byte, sum;
    logic            carry;
    logic            last;

    assign last   = (idx_q == IW'(NBYTES - 1));
    assign a_byte = a_q[{idx_q, 3'b000} +: BYTE_W];
    assign b_byte = b_q[{idx_q, 3'b000} +: BYTE_W];

    csa_8 u_csa (
        .A     (a_byte),
        .B     (b_byte),
        .CIN   (carry_q),
        .SUM   (sum),
        .CARRY (carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START_VALID) state_d = RUN;
            RUN:     if (last)        state_d = DONE;
            DONE:    if (DONE_READY)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (START_VALID) begin
                    // Subtract as A + ~B + 1; B is stored already inverted.
                    a_q     <= A;
                    b_q     <= SUB ? ~B : B;
                    carry_q <= SUB | CIN;
                    idx_q   <= '0;
                end
                RUN: begin
                    result_q[{idx_q, 3'b000} +: BYTE_W] <= sum;
                    carry_q <= carry;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q <= carry;
                        ovf_q  <= ~(a_q[W-1] ^ b_q[W-1]) & (sum[7] ^ a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign START_READY = (state_q == IDLE);
    assign DONE_VALID  = (state_q == DONE);
    assign RESULT      = result_q;
    assign COUT        = cout_q;
    assign OVF         = ovf_q;

endmodule

// File: doc/csa_seq_adder.md
Name: csa_seq_adder

Overview:
- Multi-precision adder/subtractor controller built around one shared 8-bit carry-select adder (csa_8).
- Captures two wide operands through a valid/ready handshake. Feeds them to csa_8 one byte per cycle, least significant byte first, chaining the carry through a register.
- Returns the full result, carry-out and signed overflow through a second valid/ready handshake.
- Lets the lab datapath add 32-bit (or wider) words without replicating the 8-bit adder.

Parameters:
- NBYTES, 4, number of operand bytes; operand width W = 8*NBYTES; legal range 1..16.

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- RST_N  input  1  synchronous reset, active-low; sampled on rising edge of CLK.
- START_VALID  input  1  request carries valid operands.
- START_READY  output  1  block can accept a request.
- A  input  W  operand A.
- B  input  W  operand B.
- CIN  input  1  carry-in for add mode; ignored in subtract mode.
- SUB  input  1  0 = A+B+CIN; 1 = A-B (B inverted, carry-in forced to 1).
- RESULT  output  W  sum/difference.
- COUT  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- OVF  output  1  two's-complement overflow of the W-bit operation.
- DONE_VALID  output  1  RESULT/COUT/OVF valid.
- DONE_READY  input  1  consumer accepts the result.

Behaviour:
- Reset (RST_N=0 at an edge):
  - state goes to IDLE; byte index 0; carry register 0.
  - RESULT=0, COUT=0, OVF=0, DONE_VALID=0, START_READY=1 from the following cycle.
  - Reset overrides everything, including mid-RUN and DONE; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - START_READY=1.
    - On START_VALID=1, register A, B (B inverted when SUB=1) and SUB; carry register = SUB ? 1 : CIN; index=0; go to RUN.
  - RUN:
    - START_READY=0.
    - Each cycle, csa_8 gets byte[index] of the A register, byte[index] of the B register and the carry register.
    - Its SUM writes RESULT byte[index]; its CARRY writes the carry register; index increments.
    - When index = NBYTES-1:
      - COUT = csa_8 CARRY.
      - OVF = (A_msb XNOR Beff_msb) AND (SUM_msb XOR A_msb), where Beff is the possibly inverted B.
      - Go to DONE.
  - DONE:
    - DONE_VALID=1; RESULT, COUT and OVF are held stable.
    - On DONE_READY=1, go to IDLE and drop DONE_VALID.
- Latency: DONE_VALID rises exactly NBYTES cycles after the accepting edge. With the one-cycle IDLE return, peak throughput is one operation per NBYTES+2 cycles.
- START_READY is a function of state only; no combinational path from DONE_READY or START_VALID.
- A, B, CIN and SUB are sampled only at the accepting edge. Changes while in RUN or DONE have no effect.
- START_VALID asserted while not in IDLE: not accepted and not queued; the requester holds it until START_READY.
- RESULT bytes not yet computed during RUN hold their previous values. Only DONE_VALID qualifies RESULT.
- Wrap-around: all arithmetic is modulo 2^W; the carry out of the top byte appears only on COUT.
- NBYTES=1: RUN lasts a single cycle.
- The block contains no combinational path through csa_8 to any output; every output is registered.

Decomposition:
- Shared package/include csa_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - BYTE_W=8;
  - index width function clog2(NBYTES).
- Sub-module: exactly one instance of existing csa_8 (A, B, CIN, SUM, CARRY). The controller is the FSM, operand/result registers and byte mux.

Test Plan (NBYTES=4):
- Basic add: A=0x000000FF, B=0x00000001, CIN=0, SUB=0 -> RESULT=0x00000100, COUT=0, OVF=0; DONE_VALID exactly 4 cycles after the accept edge.
- Full carry chain: A=0xFFFFFFFF, B=0x00000000, CIN=1 -> RESULT=0x00000000, COUT=1, OVF=0.
- Subtract and overflow, two operations:
  - A=0x00000005, B=0x00000007, SUB=1 -> RESULT=0xFFFFFFFE, COUT=0, OVF=0.
  - A=0x7FFFFFFF, B=0x00000001, SUB=0 -> RESULT=0x80000000, OVF=1.
- Backpressure: finish any op, then hold DONE_READY=0 for 5 cycles while driving START_VALID=1 with new operands.
  - RESULT/COUT/OVF stay stable; START_READY=0; the new request is accepted only one cycle after DONE_READY=1.
- Reset mid-operation: drop RST_N for one edge while index=2 in RUN.
  - Next cycle: state IDLE, RESULT=0, DONE_VALID=0, START_READY=1.
  - A following op A=0x01FF01FF + B=0x00010001 gives RESULT=0x02000200, COUT=0.
- Random regression: 1000 random A/B/CIN/SUB with random DONE_READY delays 0-3 cycles -> every result matches a W-bit reference model, including COUT and OVF.
